// File: rtl/fpu_pkg.sv
// FPU-local types and constants for the multiplier arbiter.
package fpu_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } fpu_mult_arb_state_e;

    localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;
endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V FP types used across the FPU blocks.
package riscv_pkg;
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from the last winner + 1; pointer advances only on a grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);
    localparam int IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] rr_last_q, rr_last_d;
    logic [IdxW-1:0] j;
    logic            found;
    int              jj;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        jj    = 0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            jj = int'(rr_last_q) + 1 + k;
            if (jj >= NUM_REQ) jj = jj - NUM_REQ;
            j = IdxW'(jj);
            if (!found && i_req[j]) begin
                found = 1'b1;
                o_idx = j;
            end
        end
        if (i_en && found) o_gnt[o_idx] = 1'b1;
        rr_last_d = (i_en && found) ? o_idx : rr_last_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) rr_last_q <= IdxW'(NUM_REQ - 1);
        else       rr_last_q <= rr_last_d;
    end
endmodule

// File: rtl/fpu_mult_arbiter.sv
// Shares one fpu_mult_unit between NUM_REQ requesters, one operation in flight.
// Optional FPU_MULT_ARB_NANBOX_CHECK_EN: improperly boxed single operands become canonical NaN.
module fpu_mult_arbiter
    import fpu_pkg::*;
    import riscv_pkg::*;
#(
    parameter int FP_WIDTH_D = 64,
    parameter int NUM_REQ    = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_flush,
    input  logic [NUM_REQ-1:0]                  i_req_valid,
    output logic [NUM_REQ-1:0]                  o_req_ready,
    input  logic [NUM_REQ-1:0]                  i_req_is_double,
    input  logic [NUM_REQ-1:0][FP_WIDTH_D-1:0]  i_req_operand_a,
    input  logic [NUM_REQ-1:0][FP_WIDTH_D-1:0]  i_req_operand_b,
    input  logic [NUM_REQ-1:0][2:0]             i_req_rm,
    input  logic [NUM_REQ-1:0][4:0]             i_req_dest,
    output logic                                o_mu_valid,
    output logic                                o_mu_is_double,
    output logic [31:0]                         o_mu_a_s,
    output logic [31:0]                         o_mu_b_s,
    output logic [FP_WIDTH_D-1:0]               o_mu_a_d,
    output logic [FP_WIDTH_D-1:0]               o_mu_b_d,
    output logic [2:0]                          o_mu_rm,
    output logic [4:0]                          o_mu_dest,
    input  logic                                i_mu_start,
    input  logic                                i_mu_valid,
    input  logic [FP_WIDTH_D-1:0]               i_mu_result,
    input  fp_flags_t                           i_mu_flags,
    input  logic [4:0]                          i_mu_dest,
    output logic [NUM_REQ-1:0]                  o_rsp_valid,
    input  logic [NUM_REQ-1:0]                  i_rsp_ready,
    output logic [FP_WIDTH_D-1:0]               o_rsp_result,
    output fp_flags_t                           o_rsp_flags,
    output logic [4:0]                          o_rsp_dest,
    output logic                                o_busy
);
    localparam int IdxW = $clog2(NUM_REQ);

    fpu_mult_arb_state_e     state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d, gnt_idx;
    logic [NUM_REQ-1:0]      gnt;
    logic                    grant_en, cap;
    logic                    dbl_q, dbl_d;
    logic [FP_WIDTH_D-1:0]   a_q, a_d, b_q, b_d;
    logic [31:0]             as_q, as_d, bs_q, bs_d, sel_as, sel_bs;
    logic [2:0]              rm_q, rm_d;
    logic [4:0]              dest_q, dest_d, rdest_q, rdest_d;
    logic [FP_WIDTH_D-1:0]   res_q, res_d;
    fp_flags_t               flags_q, flags_d;

    assign grant_en = (state_q == IDLE) && !i_flush;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req_valid),
        .i_en  (grant_en),
        .o_gnt (gnt),
        .o_idx (gnt_idx)
    );

`ifdef FPU_MULT_ARB_NANBOX_CHECK_EN
    always_comb begin
        sel_as = i_req_operand_a[gnt_idx][31:0];
        sel_bs = i_req_operand_b[gnt_idx][31:0];
        if (!i_req_is_double[gnt_idx]) begin
            if (!(&i_req_operand_a[gnt_idx][FP_WIDTH_D-1:32])) sel_as = CANON_NAN_S;
            if (!(&i_req_operand_b[gnt_idx][FP_WIDTH_D-1:32])) sel_bs = CANON_NAN_S;
        end
    end
`else
    assign sel_as = i_req_operand_a[gnt_idx][31:0];
    assign sel_bs = i_req_operand_b[gnt_idx][31:0];
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dbl_d   = dbl_q;
        a_d     = a_q;
        b_d     = b_q;
        as_d    = as_q;
        bs_d    = bs_q;
        rm_d    = rm_q;
        dest_d  = dest_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = ISSUE;
                owner_d = gnt_idx;
                dbl_d   = i_req_is_double[gnt_idx];
                a_d     = i_req_operand_a[gnt_idx];
                b_d     = i_req_operand_b[gnt_idx];
                as_d    = sel_as;
                bs_d    = sel_bs;
                rm_d    = i_req_rm[gnt_idx];
                dest_d  = i_req_dest[gnt_idx];
            end
            // A flushed op the unit already took must be drained unless its result is here now.
            ISSUE: if (i_flush)         state_d = (i_mu_start && !i_mu_valid) ? DRAIN : IDLE;
                   else if (i_mu_start) begin
                       state_d = i_mu_valid ? RESP : WAIT;
                       cap     = i_mu_valid;
                   end
            WAIT:  if (i_flush)         state_d = i_mu_valid ? IDLE : DRAIN;
                   else if (i_mu_valid) begin
                       state_d = RESP;
                       cap     = 1'b1;
                   end
            RESP:  if (i_flush || i_rsp_ready[owner_q]) state_d = IDLE;
            DRAIN: if (i_mu_valid)      state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        res_d   = cap ? i_mu_result : res_q;
        flags_d = cap ? i_mu_flags  : flags_q;
        rdest_d = cap ? i_mu_dest   : rdest_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            dbl_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            as_q    <= '0;
            bs_q    <= '0;
            rm_q    <= '0;
            dest_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            rdest_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dbl_q   <= dbl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            as_q    <= as_d;
            bs_q    <= bs_d;
            rm_q    <= rm_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rdest_q <= rdest_d;
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        if (state_q == RESP && !i_flush) o_rsp_valid[owner_q] = 1'b1;
    end

    assign o_req_ready    = gnt;
    assign o_mu_valid     = (state_q == ISSUE);
    assign o_mu_is_double = dbl_q;
    assign o_mu_a_s       = as_q;
    assign o_mu_b_s       = bs_q;
    assign o_mu_a_d       = a_q;
    assign o_mu_b_d       = b_q;
    assign o_mu_rm        = rm_q;
    assign o_mu_dest      = dest_q;
    assign o_rsp_result   = res_q;
    assign o_rsp_flags    = flags_q;
    assign o_rsp_dest     = rdest_q;
    assign o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Bench for fpu_mult_arbiter: behavioural multiplier unit with variable latency plus a response scoreboard.
module tb_fpu_mult_arbiter;
    import riscv_pkg::*;
    localparam int NR = 2;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]         req_valid = '0, req_ready, req_dbl = '0, rsp_valid, rsp_ready = '1;
    logic [NR-1:0][63:0]   req_a = '0, req_b = '0;
    logic [NR-1:0][2:0]    req_rm = '0;
    logic [NR-1:0][4:0]    req_dest = '0;
    logic                  mu_valid, mu_dbl, mu_start, mu_rvalid, busy;
    logic [31:0]           mu_a_s, mu_b_s;
    logic [63:0]           mu_a_d, mu_b_d, mu_result, rsp_result;
    logic [2:0]            mu_rm;
    logic [4:0]            mu_dest, mu_rdest, rsp_dest;
    fp_flags_t             mu_flags, rsp_flags;

    fpu_mult_arbiter #(.FP_WIDTH_D(64), .NUM_REQ(NR)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_is_double(req_dbl),
        .i_req_operand_a(req_a), .i_req_operand_b(req_b), .i_req_rm(req_rm), .i_req_dest(req_dest),
        .o_mu_valid(mu_valid), .o_mu_is_double(mu_dbl), .o_mu_a_s(mu_a_s), .o_mu_b_s(mu_b_s),
        .o_mu_a_d(mu_a_d), .o_mu_b_d(mu_b_d), .o_mu_rm(mu_rm), .o_mu_dest(mu_dest),
        .i_mu_start(mu_start), .i_mu_valid(mu_rvalid), .i_mu_result(mu_result),
        .i_mu_flags(mu_flags), .i_mu_dest(mu_rdest),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result),
        .o_rsp_flags(rsp_flags), .o_rsp_dest(rsp_dest), .o_busy(busy)
    );

    typedef struct {logic dbl; logic [63:0] a, b; logic [2:0] rm; logic [4:0] dest;} op_t;
    typedef struct {int owner; logic [63:0] res; logic [4:0] flags; logic [4:0] dest;} exp_t;

    op_t  q0[$], q1[$];
    exp_t sb[$];
    int   grant_log[$];
    int   n_vec = 0, n_err = 0, lat = 2, rsp_cnt = 0;
    logic start_en = 1'b1;
    logic [63:0] last_res = '0;
    logic [NR-1:0] acc = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Normal singles only (the stimulus avoids denormals and overflow).
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) d = {x[31], 63'd0};
        else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [63:0] fmul(input logic dbl, input logic [63:0] ad, input logic [63:0] bd,
                                         input logic [31:0] as, input logic [31:0] bs);
        if (dbl) return $realtobits($bitstoreal(ad) * $bitstoreal(bd));
        if (as[30:23] == 8'hFF || bs[30:23] == 8'hFF) return 64'hFFFFFFFF_7FC00000;
        return {32'hFFFFFFFF, r2s(s2r(as) * s2r(bs))};
    endfunction

    function automatic logic [31:0] boxed(input logic [63:0] x, input logic dbl);
`ifdef FPU_MULT_ARB_NANBOX_CHECK_EN
        if (!dbl && x[63:32] != 32'hFFFFFFFF) return 32'h7FC00000;
`endif
        return x[31:0];
    endfunction

    function automatic op_t mk(input logic dbl, input logic [63:0] a, input logic [63:0] b,
                               input logic [2:0] rm, input logic [4:0] dest);
        op_t o;
        o.dbl = dbl; o.a = a; o.b = b; o.rm = rm; o.dest = dest;
        return o;
    endfunction

    // Behavioural multiplier: result appears lat-1 cycles after start; flags tag the rounding mode.
    logic       u_busy = 1'b0;
    int         u_cnt = 0;
    logic [63:0] u_res = '0;
    logic [4:0]  u_dest = '0;
    fp_flags_t   u_flags = '0;

    assign mu_start = mu_valid && !u_busy && start_en;
    always_comb begin
        mu_rvalid = (lat == 1) ? mu_start : (u_busy && u_cnt == 0);
        mu_result = u_res;
        mu_rdest  = u_dest;
        mu_flags  = u_flags;
        if (lat == 1) begin
            mu_result = fmul(mu_dbl, mu_a_d, mu_b_d, mu_a_s, mu_b_s);
            mu_rdest  = mu_dest;
            mu_flags  = fp_flags_t'(5'(mu_rm));
        end
    end
    always @(posedge clk) begin
        if (mu_start && lat > 1) begin
            u_busy  <= 1'b1;
            u_cnt   <= lat - 2;
            u_res   <= fmul(mu_dbl, mu_a_d, mu_b_d, mu_a_s, mu_b_s);
            u_dest  <= mu_dest;
            u_flags <= fp_flags_t'(5'(mu_rm));
        end else if (u_busy) begin
            if (u_cnt == 0) u_busy <= 1'b0;
            else            u_cnt  <= u_cnt - 1;
        end
    end

    task automatic set_lane(input int i, input op_t o);
        req_dbl[i] = o.dbl; req_a[i] = o.a; req_b[i] = o.b; req_rm[i] = o.rm; req_dest[i] = o.dest;
    endtask

    // Requesters hold each op until the grant they saw at the previous negedge is consumed.
    always @(posedge clk) begin
        #1;
        if (acc[0] && q0.size() > 0) q0.delete(0);
        if (acc[1] && q1.size() > 0) q1.delete(0);
        acc = '0;
        req_valid[0] = (q0.size() != 0);
        req_valid[1] = (q1.size() != 0);
        if (req_valid[0]) set_lane(0, q0[0]);
        if (req_valid[1]) set_lane(1, q1[0]);
    end

    always @(negedge clk) begin
        exp_t e;
        int o;
        if (!rst) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) begin
                e.owner = i;
                e.res   = fmul(req_dbl[i], req_a[i], req_b[i], boxed(req_a[i], req_dbl[i]), boxed(req_b[i], req_dbl[i]));
                e.flags = 5'(req_rm[i]);
                e.dest  = req_dest[i];
                sb.push_back(e);
                grant_log.push_back(i);
                acc[i] = 1'b1;
            end
            if (rsp_valid != '0) begin
                o = 0;
                for (int i = 0; i < NR; i++) if (rsp_valid[i]) o = i;
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                if (rsp_ready[o]) begin
                    if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_owner", 64'(o), 64'(e.owner));
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                        chk("rsp_dest", 64'(rsp_dest), 64'(e.dest));
                        last_res = rsp_result;
                        rsp_cnt++;
                    end
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("timeout_done", 64'd1, 64'd0);
    endtask

    logic [63:0] s_a[4] = '{64'hFFFFFFFF_3FC00000, 64'hFFFFFFFF_40400000, 64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_41200000};
    logic [63:0] s_b[4] = '{64'hFFFFFFFF_40000000, 64'hFFFFFFFF_3F000000, 64'hFFFFFFFF_3FA00000, 64'hFFFFFFFF_3E800000};
    real d_a[4] = '{2.5, -1.5, 0.125, 1.0e10};
    real d_b[4] = '{4.0, 3.0, 8.0, 3.0};

    initial begin
        int c, n, own;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mu_valid", 64'(mu_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_mu_a_d", mu_a_d, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Contention: both lanes always valid, grants must alternate starting at 0.
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk(1'b0, s_a[k], s_b[k], 3'(k), 5'(k)));
            q1.push_back(mk(1'b1, $realtobits(d_a[k]), $realtobits(d_b[k]), 3'(k + 1), 5'(k + 8)));
        end
        wait_done(2000);
        chk("rr_count", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < grant_log.size() && k < 8; k++) chk("rr_order", 64'(grant_log[k]), 64'(k % 2));

        // Latency-1 unit: start and result in the same cycle.
        lat = 1;
        q0.push_back(mk(1'b0, s_a[0], s_b[0], 3'd0, 5'd7));
        wait_done(200);
        chk("single_result", last_res, 64'hFFFFFFFF_40400000);
        for (int k = 1; k < 4; k++) q1.push_back(mk(1'b1, $realtobits(d_a[k]), $realtobits(d_b[k]), 3'(k), 5'(k + 20)));
        wait_done(500);

        // Backpressure: payload held, non-owner ready ignored, no new grant.
        lat = 3;
        @(posedge clk); #1 rsp_ready = '0;
        q0.push_back(mk(1'b0, s_a[2], s_b[2], 3'd5, 5'd12));
        q1.push_back(mk(1'b0, s_a[3], s_b[3], 3'd6, 5'd13));
        n = 0;
        while (rsp_valid == '0 && n < 100) begin @(negedge clk); n++; end
        if (rsp_valid == '0 || sb.size() == 0) chk("timeout_bp", 64'd1, 64'd0);
        else begin
            own = sb[0].owner;
            @(posedge clk); #1 rsp_ready = ~NR'(1 << own);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("bp_valid", 64'(rsp_valid), 64'(NR'(1 << own)));
                chk("bp_result", rsp_result, sb[0].res);
                chk("bp_no_grant", 64'(req_ready), 64'd0);
            end
        end
        @(posedge clk); #1 rsp_ready = '1;
        wait_done(500);

        // Flush while waiting for the unit: drain, no response.
        lat = 4;
        q0.push_back(mk(1'b0, s_a[1], s_b[1], 3'd1, 5'd3));
        n = 0;
        @(negedge clk);
        while (!mu_start && n < 100) begin @(negedge clk); n++; end
        if (!mu_start) chk("timeout_start", 64'd0, 64'd1);
        @(posedge clk); #1 flush = 1'b1; sb.delete();
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_mu_valid", 64'(mu_valid), 64'd0);
        c = rsp_cnt;
        wait_done(200);
        chk("drain_no_rsp", 64'(rsp_cnt), 64'(c));
        lat = 2;
        q1.push_back(mk(1'b1, $realtobits(d_a[0]), $realtobits(d_b[0]), 3'd2, 5'd30));
        wait_done(200);
        chk("after_drain_rsp", 64'(rsp_cnt), 64'(c + 1));

        // Flush in ISSUE before the unit starts.
        start_en = 1'b0;
        q1.push_back(mk(1'b0, s_a[2], s_b[2], 3'd3, 5'd9));
        n = 0;
        @(negedge clk);
        while (!mu_valid && n < 100) begin @(negedge clk); n++; end
        chk("issue_mu_valid", 64'(mu_valid), 64'd1);
        @(posedge clk); #1 flush = 1'b1; sb.delete();
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("issue_flush_mu_valid", 64'(mu_valid), 64'd0);
        chk("issue_flush_busy", 64'(busy), 64'd0);
        start_en = 1'b1;
        c = rsp_cnt;
        repeat (6) @(negedge clk);
        chk("issue_flush_no_rsp", 64'(rsp_cnt), 64'(c));

        // Improperly boxed single operand.
        q0.push_back(mk(1'b0, 64'h00000000_3F800000, 64'hFFFFFFFF_40000000, 3'd0, 5'd1));
        wait_done(200);
`ifdef FPU_MULT_ARB_NANBOX_CHECK_EN
        chk("nanbox_result", last_res, 64'hFFFFFFFF_7FC00000);
`else
        chk("nanbox_result", last_res, 64'hFFFFFFFF_40000000);
`endif

        // Mixed traffic with varying unit latency.
        for (int k = 0; k < 6; k++) begin
            lat = int'($urandom_range(1, 4));
            if (k % 2 == 0) q0.push_back(mk(1'b0, s_a[k % 4], s_b[k % 4], 3'(k), 5'(k + 2)));
            else            q1.push_back(mk(1'b1, $realtobits(d_a[k % 4]), $realtobits(d_b[k % 4]), 3'(k), 5'(k + 16)));
            wait_done(300);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end
endmodule
